// File: rtl/board_ctrl.sv
// Paddle position controller: samples the buttons once per movement tick and
// moves the board with slow-then-fast acceleration, clamped to the screen edges.
module board_ctrl #(
  parameter int TICK_DIV   = 1666666,
  parameter int SCREEN_W   = 640,
  parameter int BOARD_W    = 64,
  parameter int BOARD_Y    = 296,
  parameter int X_INIT     = 288,
  parameter int STEP_SLOW  = 2,
  parameter int STEP_FAST  = 6,
  parameter int HOLD_TICKS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  output logic [9:0] board_x,
  output logic [9:0] board_y,
  output logic       tick,
  output logic       at_left,
  output logic       at_right,
  output logic [1:0] fsm_state
);

  localparam int XMAX = SCREEN_W - BOARD_W;
  localparam int CW   = $clog2(TICK_DIV);
  localparam int HW   = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        div_cnt;
  logic                 strobe;
  logic [HW-1:0]        hold_cnt, hold_nx;
  logic                 dir_right, dir_right_nx;
  logic                 want_left, want_right, want_move;
  logic                 move, move_right, move_fast;
  logic signed [10:0]   step_s, x_sum;
  logic [9:0]           x_nx;

  assign strobe     = (div_cnt == CW'(TICK_DIV - 1));
  assign want_left  = left & ~right;
  assign want_right = right & ~left;
  assign want_move  = want_left | want_right;
  assign board_y    = 10'(BOARD_Y);
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Step size is chosen from the state before the transition.
  always_comb begin
    state_nx     = state;
    hold_nx      = hold_cnt;
    dir_right_nx = dir_right;
    move         = 1'b0;
    move_right   = want_right;
    move_fast    = 1'b0;
    case (state)
      IDLE: begin
        if (want_move) begin
          move         = 1'b1;
          hold_nx      = HW'(1);
          dir_right_nx = want_right;
          state_nx     = SLOW;
        end
      end
      SLOW: begin
        if (!want_move) begin
          hold_nx  = '0;
          state_nx = IDLE;
        end else if (want_right == dir_right) begin
          move = 1'b1;
          if (hold_cnt >= HW'(HOLD_TICKS - 1)) begin
            hold_nx  = HW'(HOLD_TICKS);
            state_nx = FAST;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end else begin
          move         = 1'b1;
          hold_nx      = HW'(1);
          dir_right_nx = want_right;
        end
      end
      FAST: begin
        if (!want_move) begin
          hold_nx  = '0;
          state_nx = IDLE;
        end else if (want_right == dir_right) begin
          move      = 1'b1;
          move_fast = 1'b1;
        end else begin
          move         = 1'b1;
          hold_nx      = HW'(1);
          dir_right_nx = want_right;
          state_nx     = SLOW;
        end
      end
      default: begin
        hold_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // The sum stays below 1024 when non-negative, so bit 10 is the sign.
  always_comb begin
    step_s = move_fast ? 11'(STEP_FAST) : 11'(STEP_SLOW);
    x_sum  = move_right ? ($signed({1'b0, board_x}) + step_s)
                        : ($signed({1'b0, board_x}) - step_s);
    if (x_sum[10]) begin
      x_nx = '0;
    end else if (x_sum[9:0] > 10'(XMAX)) begin
      x_nx = 10'(XMAX);
    end else begin
      x_nx = x_sum[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      dir_right <= 1'b0;
      board_x   <= 10'(X_INIT);
      at_left   <= (X_INIT == 0);
      at_right  <= (X_INIT == XMAX);
      tick      <= 1'b0;
    end else begin
      tick <= strobe;
      if (strobe) begin
        state     <= state_nx;
        hold_cnt  <= hold_nx;
        dir_right <= dir_right_nx;
        if (move) begin
          board_x  <= x_nx;
          at_left  <= (x_nx == 10'd0);
          at_right <= (x_nx == 10'(XMAX));
        end
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl with a short tick divider: directed button sequences,
// expected positions queued per tick and checked by a tick-driven monitor.
module tb_board_ctrl;

  localparam int W = 14;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, left = 1'b0, right = 1'b0;
  logic [9:0] board_x, board_y;
  logic       tick, at_left, at_right;
  logic [1:0] fsm_state;
  logic       rst5 = 1'b1, left5 = 1'b0, right5 = 1'b0;
  logic [9:0] board_x5, board_y5;
  logic       tick5, at_left5, at_right5;
  logic [1:0] fsm_state5;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp5_q[$];
  logic [W-1:0] mon_e, mon5_e;
  logic mon_en = 1'b0, mon5_en = 1'b0;
  logic have_last = 1'b0, tick_prev = 1'b0;
  int cyc = 0, last_tick = 0;

  board_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .board_x(board_x), .board_y(board_y), .tick(tick),
    .at_left(at_left), .at_right(at_right), .fsm_state(fsm_state)
  );

  board_ctrl #(.TICK_DIV(4), .X_INIT(5)) dut5 (
    .clk(clk), .rst(rst5), .left(left5), .right(right5),
    .board_x(board_x5), .board_y(board_y5), .tick(tick5),
    .at_left(at_left5), .at_right(at_right5), .fsm_state(fsm_state5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pack(input int x, input logic [1:0] st);
    return {10'(x), (x == 0), (x == 576), st};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got x=%0d l=%0b r=%0b st=%0d, expected x=%0d l=%0b r=%0b st=%0d",
               name, got[13:4], got[3], got[2], got[1:0], exp[13:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitors sample 2 ns after the rising edge; the driver works on falling edges.
  always @(posedge clk) begin
    #2;
    if (tick && mon_en) begin
      if (exp_q.size() == 0) begin
        check_int("unexpected_tick", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("board", {board_x, at_left, at_right, fsm_state}, mon_e);
      end
      check_int("board_y", int'(board_y), 296);
      check_int("tick_width", int'(tick_prev), 0);
      if (have_last) check_int("tick_period", cyc - last_tick, 4);
    end
    if (tick) begin
      last_tick = cyc;
      have_last = 1'b1;
    end
    tick_prev = tick;
  end

  always @(posedge clk) begin
    #2;
    if (tick5 && mon5_en) begin
      if (exp5_q.size() == 0) begin
        check_int("unexpected_tick5", 1, 0);
      end else begin
        mon5_e = exp5_q.pop_front();
        check("board5", {board_x5, at_left5, at_right5, fsm_state5}, mon5_e);
      end
    end
  end

  task automatic wait_for(input bit use5);
    int n;
    n = 0;
    @(negedge clk);
    while (!(use5 ? tick5 : tick) && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!(use5 ? tick5 : tick)) check_int("tick_timeout", n, -1);
  endtask

  task automatic step(input logic l, input logic r, input int x, input logic [1:0] st);
    left  = l;
    right = r;
    exp_q.push_back(pack(x, st));
    wait_for(1'b0);
  endtask

  task automatic do_reset();
    int n;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    left      = 1'b0;
    right     = 1'b0;
    have_last = 1'b0;
    check("reset", {board_x, at_left, at_right, fsm_state}, pack(288, S_IDLE));
    check_int("reset_y", int'(board_y), 296);
    check_int("reset_tick", int'(tick), 0);
    exp_q.delete();
    exp_q.push_back(pack(288, S_IDLE));
    mon_en = 1'b1;
    n = 0;
    while (!tick && n < 12) begin
      @(negedge clk);
      n++;
    end
    check_int("first_tick_latency", n, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $finish;
  end

  initial begin
    do_reset();

    // slow moves, release to idle, both buttons ignored
    step(0, 1, 290, S_SLOW);
    step(0, 1, 292, S_SLOW);
    step(0, 1, 294, S_SLOW);
    step(0, 0, 294, S_IDLE);
    step(0, 1, 296, S_SLOW);
    step(0, 0, 296, S_IDLE);
    step(1, 1, 296, S_IDLE);
    step(0, 1, 298, S_SLOW);
    step(1, 1, 298, S_IDLE);

    // two-cycle left pulse well clear of the strobe
    right = 1'b0;
    exp_q.push_back(pack(298, S_IDLE));
    left = 1'b1;
    @(negedge clk);
    @(negedge clk);
    left = 1'b0;
    wait_for(1'b0);

    // reset asserted in the strobe cycle while in FAST with right held
    do_reset();
    for (int i = 1; i <= 20; i++)
      step(0, 1, (i <= 15) ? 288 + 2 * i : 318 + 6 * (i - 15), (i < 15) ? S_SLOW : S_FAST);
    mon_en = 1'b0;
    right  = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    // reversing out of FAST drops back to the slow step
    for (int i = 1; i <= 20; i++)
      step(0, 1, (i <= 15) ? 288 + 2 * i : 318 + 6 * (i - 15), (i < 15) ? S_SLOW : S_FAST);
    step(1, 0, 346, S_SLOW);
    step(1, 0, 344, S_SLOW);
    step(0, 0, 344, S_IDLE);

    // left wall: reaches 0 exactly at tick 58 and stays
    do_reset();
    for (int i = 1; i <= 60; i++)
      step(1, 0, (i <= 15) ? 288 - 2 * i : ((258 - 6 * (i - 15)) < 0 ? 0 : 258 - 6 * (i - 15)),
           (i < 15) ? S_SLOW : S_FAST);
    step(0, 0, 0, S_IDLE);

    // right wall: reaches 576 exactly at tick 58, then reverse
    do_reset();
    for (int i = 1; i <= 60; i++)
      step(0, 1, (i <= 15) ? 288 + 2 * i : ((318 + 6 * (i - 15)) > 576 ? 576 : 318 + 6 * (i - 15)),
           (i < 15) ? S_SLOW : S_FAST);
    step(1, 0, 574, S_SLOW);
    mon_en = 1'b0;
    check_int("queue_drained", exp_q.size(), 0);

    // second instance starting near the left edge
    @(negedge clk);
    check("reset5", {board_x5, at_left5, at_right5, fsm_state5}, {10'd5, 1'b0, 1'b0, S_IDLE});
    left5 = 1'b1;
    exp5_q.push_back({10'd3, 1'b0, 1'b0, S_SLOW});
    exp5_q.push_back({10'd1, 1'b0, 1'b0, S_SLOW});
    exp5_q.push_back({10'd0, 1'b1, 1'b0, S_SLOW});
    exp5_q.push_back({10'd0, 1'b1, 1'b0, S_SLOW});
    mon5_en = 1'b1;
    rst5    = 1'b0;
    repeat (4) wait_for(1'b1);
    mon5_en = 1'b0;
    check_int("queue5_drained", exp5_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
- Paddle ("board") position controller for the VGA breakout game.
- Sits between the debounced left/right buttons and the display stage, which consumes the board x/y coordinates.
- Updates the board position at a fixed frame-rate tick, with a slow-then-fast acceleration FSM, and clamps the board to the screen edges.
- Replaces the constant board position currently wired into the display.

Parameters:
TICK_DIV, 1666666, clk cycles per movement tick (100 MHz / 60 Hz); must be >= 2
SCREEN_W, 640, visible width in pixels
BOARD_W, 64, board width in pixels
BOARD_Y, 296, fixed board top-left y
X_INIT, 288, board x after reset; must be <= SCREEN_W-BOARD_W
STEP_SLOW, 2, pixels per tick in SLOW
STEP_FAST, 6, pixels per tick in FAST
HOLD_TICKS, 15, consecutive same-direction ticks before FAST

Ports:
clk  in  1  100 MHz master clock
rst  in  1  synchronous, active-high reset
left  in  1  debounced move-left level
right  in  1  debounced move-right level
board_x  out  10  board top-left x, 0..SCREEN_W-BOARD_W
board_y  out  10  board top-left y, constant BOARD_Y
tick  out  1  one-cycle pulse, first cycle a new board_x is valid
at_left  out  1  board_x == 0
at_right  out  1  board_x == XMAX (XMAX = SCREEN_W-BOARD_W)

Behaviour:
- Reset: one clock, synchronous, active-high; rst is sampled on the rising edge of clk.
- Reset values:
  - div counter = 0; tick = 0
  - board_x = X_INIT; board_y = BOARD_Y
  - state = IDLE; hold_cnt = 0
  - at_left = (X_INIT == 0); at_right = (X_INIT == XMAX)
- rst has priority over all other activity, including mid-movement.
- Divider:
  - counts 0..TICK_DIV-1 and wraps.
  - The internal update strobe fires in the cycle where the count equals TICK_DIV-1.
  - The first strobe occurs TICK_DIV cycles after rst deasserts.
- Inputs are sampled only in the strobe cycle. Any left/right activity between strobes is ignored.
- Direction decode at the strobe:
  - left & ~right → -1
  - right & ~left → +1
  - both or neither → 0
- FSM (transitions and moves happen only on the strobe; the step size is that of the state before the transition):
  - IDLE:
    - dir == 0: stay, no move.
    - dir != 0: move STEP_SLOW in dir, hold_cnt = 1, record dir, go to SLOW.
  - SLOW:
    - dir == recorded dir: move STEP_SLOW, hold_cnt += 1; if the new hold_cnt == HOLD_TICKS, go to FAST.
    - dir == 0: no move, hold_cnt = 0, go to IDLE.
    - opposite dir: move STEP_SLOW in the new dir, hold_cnt = 1, record the new dir, stay in SLOW.
  - FAST:
    - same dir: move STEP_FAST.
    - dir == 0: go to IDLE with no move.
    - opposite dir: move STEP_SLOW in the new dir, hold_cnt = 1, go to SLOW.
  - hold_cnt saturates at HOLD_TICKS.
- Arithmetic and clamping:
  - Compute next x in 11-bit signed.
  - x - step < 0 → 0; x + step > XMAX → XMAX.
  - A clamped move still advances the FSM and hold_cnt normally (pushing into a wall keeps accelerating).
- Output timing:
  - board_x, at_left and at_right are registered and update together one cycle after the strobe.
  - tick is high for exactly that one cycle.
  - The flags are never inconsistent with board_x.
- board_y is constant BOARD_Y, including during reset.

Test Plan:
- Set TICK_DIV=4 for simulation.
- Reset release → board_x=288, board_y=296, at_left=0, at_right=0; first tick pulse 4 cycles after rst deasserts, then every 4 cycles, each exactly 1 cycle wide.
- Hold right for 3 ticks → board_x 290, 292, 294; release → the next tick leaves 294 and the FSM returns to IDLE; a further right press moves STEP_SLOW again (296).
- From reset, hold left → after ticks 1..15 x=258 (slow); tick 16 → 252, tick 17 → 246 (fast); keep holding → x=0 exactly at tick 58, at_left=1 in the same cycle; ticks 59+ stay at 0 with at_left=1.
- X_INIT=5, hold left → x 3, 1, 0 (clamped), at_left=1; hold right from reset for 58 ticks → x=576, at_right=1, held there.
- In FAST moving right, switch to left → the next tick moves -2 (SLOW).
- Both buttons pressed → no movement, state IDLE.
- A 2-cycle left pulse that does not overlap a strobe → no movement.
- Assert rst for one cycle while in FAST at x=400 → the next cycle shows x=288, tick=0, state IDLE; the divider restarts and the first tick comes 4 cycles after rst deasserts.
